// File: rtl/qe_input_sequencer.sv
// Input sequencer for the quadratic-equation/MAC block: buffers host-written (a,x) pairs,
// replays them one per cycle on start, then captures the downstream result.
module qe_input_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_a,
  input  logic [7:0]    wr_x,
  input  logic          cfg_mode,
  input  logic [7:0]    cfg_b,
  input  logic [7:0]    cfg_c,
  input  logic          start,
  input  logic          abort,
  input  logic          res_valid,
  input  logic [15:0]   res_data,
  output logic [7:0]    in_a,
  output logic [7:0]    in_x,
  output logic [7:0]    in_b,
  output logic [7:0]    in_c,
  output logic          mode,
  output logic          valid_in,
  output logic          last_input,
  output logic          busy,
  output logic          done,
  output logic [15:0]   result_q,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES} state_t;

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_t        state, state_next;
  logic [7:0]    mem_a [DEPTH];
  logic [7:0]    mem_x [DEPTH];
  logic [AW-1:0] ptr;

  logic load_run, advance, end_stream, capture, cancel, do_write, drop_write, reject;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (start && count != '0) state_next = STREAM;
      STREAM:   if (abort || last_input) state_next = abort ? IDLE : WAIT_RES;
      WAIT_RES: if (abort || res_valid) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Decode the current state into datapath strobes; abort always wins over progress.
  always_comb begin
    load_run   = 1'b0;
    advance    = 1'b0;
    end_stream = 1'b0;
    capture    = 1'b0;
    cancel     = 1'b0;
    do_write   = 1'b0;
    drop_write = 1'b0;
    reject     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (count == '0) reject = 1'b1;
          else             load_run = 1'b1;
        end else if (wr_en) begin
          if (count == FULL) drop_write = 1'b1;
          else               do_write = 1'b1;
        end
      end
      STREAM: begin
        if (abort)           cancel = 1'b1;
        else if (last_input) end_stream = 1'b1;
        else                 advance = 1'b1;
      end
      WAIT_RES: begin
        if (abort)          cancel = 1'b1;
        else if (res_valid) capture = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_a[count[AW-1:0]] <= wr_a;
      mem_x[count[AW-1:0]] <= wr_x;
    end
  end

  // The first beat is loaded on the start edge so valid_in rises the very next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_a <= '0; in_x <= '0; in_b <= '0; in_c <= '0;
      mode <= 1'b0; valid_in <= 1'b0; last_input <= 1'b0;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0;
      result_q <= '0; count <= '0; ovf <= 1'b0; ptr <= '0;
    end else begin
      done <= 1'b0;
      err  <= reject;
      busy <= (state_next != IDLE);
      if (do_write)   count <= count + ONE;
      if (drop_write) ovf <= 1'b1;
      if (load_run) begin
        mode       <= cfg_mode;
        in_b       <= cfg_b;
        in_c       <= cfg_c;
        in_a       <= mem_a[0];
        in_x       <= mem_x[0];
        valid_in   <= 1'b1;
        last_input <= !cfg_mode || (count == ONE);
        ptr        <= PTR_ONE;
      end
      if (advance) begin
        in_a       <= mem_a[ptr];
        in_x       <= mem_x[ptr];
        last_input <= ({1'b0, ptr} == count - ONE);
        ptr        <= ptr + PTR_ONE;
      end
      if (end_stream) begin
        valid_in   <= 1'b0;
        last_input <= 1'b0;
      end
      if (cancel || capture) begin
        valid_in   <= 1'b0;
        last_input <= 1'b0;
        in_a <= '0; in_x <= '0; in_b <= '0; in_c <= '0;
        mode <= 1'b0;
      end
      if (capture) begin
        result_q <= res_data;
        done     <= 1'b1;
        count    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_qe_input_sequencer.sv
// Scoreboard bench for qe_input_sequencer: a queue-based model predicts each streamed beat
// and each captured result; a negedge monitor pops and compares them.
module tb_qe_input_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, cfg_mode, start, abort, res_valid;
  logic [7:0]  wr_a, wr_x, cfg_b, cfg_c;
  logic [15:0] res_data;
  logic [7:0]  in_a, in_x, in_b, in_c;
  logic        mode, valid_in, last_input, busy, done, ovf, err;
  logic [15:0] result_q;
  logic [AW:0] count;

  int tests = 0;
  int failures = 0;

  logic [15:0] model_mem[$];
  bit          model_ovf;
  logic [15:0] model_res;
  logic [63:0] exp_beats[$];
  logic [15:0] exp_res[$];

  qe_input_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_a(wr_a), .wr_x(wr_x),
    .cfg_mode(cfg_mode), .cfg_b(cfg_b), .cfg_c(cfg_c), .start(start), .abort(abort),
    .res_valid(res_valid), .res_data(res_data), .in_a(in_a), .in_x(in_x), .in_b(in_b),
    .in_c(in_c), .mode(mode), .valid_in(valid_in), .last_input(last_input), .busy(busy),
    .done(done), .result_q(result_q), .count(count), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outputs();
    return {in_a, in_x, in_b, in_c, mode, valid_in, last_input, busy, done, ovf, err,
            result_q, 11'(count)};
  endfunction

  // Monitor: every presented beat and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (reset) begin
      if (valid_in) begin
        if (exp_beats.size() == 0) check_output("beat_unexpected", {in_a, in_x}, 64'hx);
        else check_output("beat", {30'd0, in_a, in_x, in_b, in_c, mode, last_input},
                          exp_beats.pop_front());
      end
      if (done) begin
        if (exp_res.size() == 0) check_output("done_unexpected", result_q, 64'hx);
        else check_output("result_q", result_q, exp_res.pop_front());
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] x);
    wr_en = 1'b1; wr_a = a; wr_x = x;
    tick();
    wr_en = 1'b0;
    if (model_mem.size() < DEPTH) model_mem.push_back({a, x});
    else model_ovf = 1'b1;
    check_output("wr_count", count, model_mem.size());
    check_output("wr_ovf", ovf, model_ovf);
  endtask

  // abort_at: -1 no abort, 0 abort while waiting for the result, k>0 abort on beat k.
  task automatic run_once(input bit m, input logic [7:0] b, input logic [7:0] c,
                          input int abort_at, input logic [15:0] res, input bit with_wr);
    int beats, pushed, size0;
    logic [15:0] e;
    size0 = model_mem.size();
    start = 1'b1; cfg_mode = m; cfg_b = b; cfg_c = c;
    wr_en = with_wr; wr_a = 8'hEE; wr_x = 8'hDD;
    if (size0 == 0) begin
      tick();
      start = 1'b0; wr_en = 1'b0;
      check_output("err_pulse", err, 1);
      check_output("err_busy", busy, 0);
      check_output("err_valid", valid_in, 0);
      tick();
      check_output("err_clear", err, 0);
      return;
    end
    beats  = m ? size0 : 1;
    pushed = (abort_at > 0) ? abort_at : beats;
    for (int i = 0; i < pushed; i++) begin
      e = model_mem[m ? i : 0];
      exp_beats.push_back({30'd0, e, b, c, m, (i == beats - 1)});
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    check_output("run_busy", busy, 1);
    check_output("run_count", count, size0);
    if (abort_at > 0) begin
      repeat (abort_at - 1) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_output("abort_state", {valid_in, last_input, busy, done, in_a}, 0);
      check_output("abort_count", count, size0);
      return;
    end
    for (int i = 0; i < beats + 4 && valid_in; i++) tick();
    check_output("stream_end", valid_in, 0);
    check_output("wait_busy", busy, 1);
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
      wr_en = 1'($urandom); start = 1'($urandom); wr_a = 8'($urandom);
      tick();
    end
    wr_en = 1'b0; start = 1'b0;
    check_output("busy_ignore", {count, ovf, err}, {size0[AW:0], model_ovf, 1'b0});
    if (abort_at == 0) begin
      abort = 1'b1; res_valid = 1'($urandom); res_data = 16'hDEAD;
      tick();
      abort = 1'b0; res_valid = 1'b0;
      check_output("wabort_state", {busy, done}, 0);
      check_output("wabort_keep", {result_q, 11'(count)}, {model_res, 11'(size0)});
      return;
    end
    res_valid = 1'b1; res_data = res;
    exp_res.push_back(res);
    tick();
    res_valid = 1'b0;
    check_output("done_pulse", done, 1);
    check_output("done_clear", {busy, 11'(count), in_b, in_c, mode}, 0);
    model_mem.delete();
    model_res = res;
  endtask

  initial begin
    int n, beats, abort_at;
    bit m;
    reset = 1'b0; wr_en = 0; wr_a = 0; wr_x = 0; cfg_mode = 0; cfg_b = 0; cfg_c = 0;
    start = 0; abort = 0; res_valid = 0; res_data = 0;
    model_ovf = 1'b0; model_res = '0;
    #3;
    check_output("reset_outputs", all_outputs(), 0);
    tick();
    reset = 1'b1;
    tick();

    apply_stimulus(8'd2, 8'd3);
    apply_stimulus(8'd4, 8'd5);
    apply_stimulus(8'd1, 8'd7);
    run_once(1'b1, 8'd0, 8'd0, -1, 16'h0022, 1'b0);

    apply_stimulus(8'd3, 8'd2);
    run_once(1'b0, 8'd4, 8'd5, -1, 16'h0015, 1'b0);

    // Result strobes and abort outside a run must be ignored.
    res_valid = 1'b1; res_data = 16'hBEEF; abort = 1'b1;
    tick();
    res_valid = 1'b0; abort = 1'b0;
    check_output("idle_res_ignored", {result_q, done, busy}, {model_res, 2'b00});

    for (int i = 0; i < DEPTH + 1; i++) apply_stimulus(8'($urandom), 8'($urandom));
    run_once(1'b1, 8'h11, 8'h22, -1, 16'h1234, 1'b0);

    run_once(1'b1, 8'h33, 8'h44, -1, 16'h5555, 1'b0);

    for (int i = 0; i < 5; i++) apply_stimulus(8'(10 + i), 8'(20 + i));
    run_once(1'b1, 8'h01, 8'h02, 2, 16'h0, 1'b0);
    run_once(1'b1, 8'h01, 8'h02, -1, 16'h0A0A, 1'b0);

    apply_stimulus(8'h5A, 8'hA5);
    apply_stimulus(8'h3C, 8'hC3);
    run_once(1'b1, 8'h07, 8'h08, -1, 16'h0F0F, 1'b1);

    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, 18);
      for (int i = 0; i < n; i++) apply_stimulus(8'($urandom), 8'($urandom));
      m = 1'($urandom);
      beats = (model_mem.size() == 0) ? 0 : (m ? model_mem.size() : 1);
      abort_at = -1;
      case ($urandom_range(0, 4))
        0: if (beats > 0) abort_at = $urandom_range(1, beats);
        1: if (beats > 0) abort_at = 0;
        default: ;
      endcase
      run_once(m, 8'($urandom), 8'($urandom), abort_at, 16'($urandom), 1'($urandom));
    end

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 4; i++) apply_stimulus(8'(i + 1), 8'(i + 9));
    exp_beats.push_back({30'd0, model_mem[0], 8'h66, 8'h77, 1'b1, 1'b0});
    start = 1'b1; cfg_mode = 1'b1; cfg_b = 8'h66; cfg_c = 8'h77;
    tick();
    start = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1 check_output("async_reset", all_outputs(), 0);
    model_mem.delete(); model_ovf = 1'b0; model_res = '0;
    #4 reset = 1'b1;
    tick();
    check_output("post_reset_count", count, 0);
    apply_stimulus(8'h81, 8'h18);
    run_once(1'b0, 8'h09, 8'h0A, -1, 16'h7777, 1'b0);

    tick();
    check_output("scoreboard_drain", {32'(exp_beats.size()), 32'(exp_res.size())}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
